if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch front end of the my_mips_sopc pipeline. It is the first stage clocked directly by the SOPC clock and reset.
- Generates the PC and drives the instruction ROM (ce/addr).
- Registers the returned instruction into the IF/ID pipeline register for the decode stage.
- Handles stall, flush (exception redirect) and branch redirect with a single architectural delay slot.

Parameters:
- ADDR_W, 32, width of PC and ROM address.
- INST_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset release.

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst  in  1  asynchronous, active-low reset; asserting it clears all state immediately.
- stall_if  in  1  hold PC (from ctrl).
- stall_id  in  1  hold IF/ID register (from ctrl).
- flush  in  1  discard in-flight fetch and redirect to new_pc (exception/eret).
- new_pc  in  ADDR_W  flush redirect target.
- branch_flag  in  1  taken branch/jump resolved in ID.
- branch_target  in  ADDR_W  branch/jump destination.
- rom_data  in  INST_W  ROM read data, combinational on rom_addr.
- rom_ce  out  1  ROM chip enable.
- rom_addr  out  ADDR_W  current PC.
- id_pc  out  ADDR_W  PC of the instruction presented to ID.
- id_inst  out  INST_W  instruction presented to ID.
- id_valid  out  1  id_inst is a real fetched instruction (0 = bubble/NOP).

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, rom_ce=0.
  - id_pc=0, id_inst=0 (NOP), id_valid=0.
- rom_ce is registered:
  - It goes 1 on the first rising edge with rst=1, and stays 1 until the next reset.
  - pc does not advance on any edge where rom_ce was 0. The first fetch of RESET_PC is therefore visible on rom_addr during the first cycle after release, and reaches id_inst one edge later.
- PC next-state, evaluated each edge when rom_ce=1, in priority order:
  - flush → new_pc.
  - stall_if → hold.
  - branch_flag → branch_target.
  - Otherwise → pc+4.
- Address rules:
  - The low 2 bits of new_pc and branch_target are forced to 00.
  - pc+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC → 0).
- Delay slot: when branch_flag is high, the instruction currently at rom_addr is the delay slot. It is captured into IF/ID normally on that same edge, and the next fetch is branch_target.
- IF/ID register update per edge, in priority order:
  - flush → bubble (id_pc=0, id_inst=0, id_valid=0).
  - stall_if=1 and stall_id=0 → bubble.
  - stall_id=1 → hold all three outputs.
  - Otherwise → id_pc=pc, id_inst=rom_data, id_valid=rom_ce.
- stall_id=1 with stall_if=0 is illegal from ctrl. The block still resolves it as: PC advances, IF/ID holds. The bench flags this combination.
- Simultaneous events:
  - flush overrides stall and branch in both PC and IF/ID.
  - branch_flag together with stall_if: PC holds. ID is responsible for re-asserting branch_flag until the stall clears; the target is not latched internally.
- Reset mid-operation: all outputs return to reset values immediately. Fetch restarts from RESET_PC under the same one-cycle rom_ce latency.
- Latency: rom_addr → id_inst is 1 cycle. Redirect → first target fetch visible on rom_addr is 1 cycle after the redirect edge.

Decomposition:
- defines.v holds:
  - `ZERO_WORD`, `NOP_INST` (32'h0).
  - `inst_addr_bus` / `inst_bus` width macros.
  - The reset level macro for rst (active-low value).
- One sub-module, pc_reg: PC register, rom_ce generation and next-PC priority mux.
- The IF/ID register lives in the if_stage top.

Test Plan:
- Reset release at t=195ns with rom_data = ROM[pc>>2] → rom_ce=1 at the first edge. rom_addr shows 0, 4, 8 on successive cycles. id_inst shows ROM[0] one edge after rom_addr=0, with id_valid=1.
- Sequential fetch: pc reaches 32'h10 → id_pc=32'h10 next cycle. Start with pc=32'hFFFF_FFFC (via flush, new_pc=32'hFFFF_FFFC), then one free edge → rom_addr=0 (wrap).
- Branch: branch_flag=1, branch_target=32'h40 while rom_addr=32'h8 → id_pc=32'h8 (delay slot) and rom_addr=32'h40 on the same edge. Next edge: id_pc=32'h40. branch_target=32'h43 → rom_addr=32'h40.
- Stall: stall_if=stall_id=1 for 3 cycles at rom_addr=32'h14 → rom_addr, id_pc, id_inst are frozen. Then stall_if=1, stall_id=0 for 1 cycle → id_valid=0, id_inst=0, rom_addr still 32'h14.
- Flush priority: flush=1, new_pc=32'h20, with stall_if=1 and branch_flag=1 (target 32'h80) → rom_addr=32'h20, id_valid=0, id_inst=0.
- Async reset mid-run: drive rst=0 between edges while rom_addr=32'h30 → rom_ce, id_valid and id_inst go 0 immediately without a clock edge. After release, the fetch sequence restarts at 0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared constants and select encodings for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned INST_ADDR_BUS_W = 32;
  localparam int unsigned INST_BUS_W      = 32;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] NOP_INST  = 32'h0000_0000;

  // Level of rst that holds the stage in reset.
  localparam logic RST_ENABLE = 1'b0;

  // Next-PC source, listed from highest to lowest priority.
  typedef enum logic [1:0] {
    PC_SEL_FLUSH,
    PC_SEL_HOLD,
    PC_SEL_BRANCH,
    PC_SEL_SEQ
  } pc_sel_e;

  // IF/ID register action per edge.
  typedef enum logic [1:0] {
    IFID_BUBBLE,
    IFID_HOLD,
    IFID_LOAD
  } ifid_act_e;

  // Force a redirect target onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// PC register, registered ROM chip enable and next-PC priority mux.
module pc_reg
  import if_stage_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              ce
);

  pc_sel_e           pc_sel;
  logic [ADDR_W-1:0] pc_next;

  // Select the next PC source: flush, then stall, then branch, then sequential.
  always_comb begin
    pc_sel = PC_SEL_SEQ;
    if (flush)
      pc_sel = PC_SEL_FLUSH;
    else if (stall_if)
      pc_sel = PC_SEL_HOLD;
    else if (branch_flag)
      pc_sel = PC_SEL_BRANCH;
  end

  // Form the next PC; redirect targets are word-aligned, pc+4 wraps naturally.
  always_comb begin
    pc_next = pc + ADDR_W'(4);
    unique case (pc_sel)
      PC_SEL_FLUSH:  pc_next = {new_pc[ADDR_W-1:2], 2'b00};
      PC_SEL_HOLD:   pc_next = pc;
      PC_SEL_BRANCH: pc_next = {branch_target[ADDR_W-1:2], 2'b00};
      default:       pc_next = pc + ADDR_W'(4);
    endcase
  end

  // The enable rises on the first edge out of reset; PC only moves once it is set.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      ce <= 1'b0;
      pc <= RESET_PC;
    end else begin
      ce <= 1'b1;
      if (ce)
        pc <= pc_next;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, ROM drive and IF/ID pipeline register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [INST_W-1:0] rom_data,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid
);

  ifid_act_e ifid_act;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .stall_if      (stall_if),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .pc            (rom_addr),
    .ce            (rom_ce)
  );

  // Decide the IF/ID action: a stalled IF feeding a running ID inserts a bubble.
  always_comb begin
    ifid_act = IFID_LOAD;
    if (flush)
      ifid_act = IFID_BUBBLE;
    else if (stall_if && !stall_id)
      ifid_act = IFID_BUBBLE;
    else if (stall_id)
      ifid_act = IFID_HOLD;
  end

  // IF/ID pipeline register; the fetched word is marked valid only once fetching is enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      id_pc    <= '0;
      id_inst  <= '0;
      id_valid <= 1'b0;
    end else begin
      unique case (ifid_act)
        IFID_BUBBLE: begin
          id_pc    <= '0;
          id_inst  <= '0;
          id_valid <= 1'b0;
        end
        IFID_HOLD: begin
          id_pc    <= id_pc;
          id_inst  <= id_inst;
          id_valid <= id_valid;
        end
        default: begin
          id_pc    <= rom_addr;
          id_inst  <= rom_data;
          id_valid <= rom_ce;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
module tb_if_stage;

  logic        clk = 1'b1;
  logic        rst;
  logic        stall_if, stall_id, flush, branch_flag;
  logic [31:0] new_pc, branch_target;
  logic [31:0] rom_data;
  logic        rom_ce;
  logic [31:0] rom_addr, id_pc, id_inst;
  logic        id_valid;

  int checks = 0;
  int errors = 0;

  // Posedges at 10, 20, 30 ...; inputs driven and outputs sampled on negedges.
  always #5 clk = ~clk;

  // ROM contents: a fixed scramble of the word address, distinct per word.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC0DE_5A00;
  endfunction

  assign rom_data = rom_word(rom_addr);

  if_stage #(
    .ADDR_W   (32),
    .INST_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_if      (stall_if),
    .stall_id      (stall_id),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .rom_data      (rom_data),
    .rom_ce        (rom_ce),
    .rom_addr      (rom_addr),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_valid      (id_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock edge, returning at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Ctrl must never stall ID while IF runs.
  always @(negedge clk) begin
    if (rst && stall_id && !stall_if) begin
      errors++;
      $display("FAIL illegal_stall observed stall_id=1 stall_if=0 expected not both");
    end
  end

  initial begin
    rst = 1'b0; stall_if = 1'b0; stall_id = 1'b0; flush = 1'b0;
    branch_flag = 1'b0; new_pc = '0; branch_target = '0;

    #1;
    check("rst_ce",    32'(rom_ce),   32'h0);
    check("rst_addr",  rom_addr,      32'h0);
    check("rst_idpc",  id_pc,         32'h0);
    check("rst_inst",  id_inst,       32'h0);
    check("rst_valid", 32'(id_valid), 32'h0);

    #194 rst = 1'b1;          // t=195, first active edge at 200
    @(posedge clk); @(negedge clk);
    check("first_ce",    32'(rom_ce),   32'h1);
    check("first_addr",  rom_addr,      32'h0);
    check("first_valid", 32'(id_valid), 32'h0);

    step();
    check("seq_addr4",  rom_addr,      32'h4);
    check("seq_inst0",  id_inst,       rom_word(32'h0));
    check("seq_valid0", 32'(id_valid), 32'h1);
    step();
    check("seq_addr8",  rom_addr, 32'h8);
    check("seq_idpc4",  id_pc,    32'h4);

    // Branch at 0x8: delay slot captured, target fetched next
    branch_flag = 1'b1; branch_target = 32'h40;
    step();
    check("br_addr",   rom_addr,      32'h40);
    check("br_slot",   id_pc,         32'h8);
    check("br_sinst",  id_inst,       rom_word(32'h8));
    check("br_svalid", 32'(id_valid), 32'h1);
    branch_flag = 1'b0;
    step();
    check("br_tgt_idpc", id_pc,    32'h40);
    check("br_next",     rom_addr, 32'h44);
    branch_flag = 1'b1; branch_target = 32'h43;
    step();
    check("br_align", rom_addr, 32'h40);
    check("br_idpc",  id_pc,    32'h44);
    branch_flag = 1'b0;

    // Walk to 0x14 via flush to 0xC
    flush = 1'b1; new_pc = 32'hC;
    step();
    flush = 1'b0;
    check("fl_addr",  rom_addr,      32'hC);
    check("fl_valid", 32'(id_valid), 32'h0);
    step();
    step();
    check("seq_addr14", rom_addr, 32'h14);
    check("seq_idpc10", id_pc,    32'h10);

    // Full stall for three cycles
    stall_if = 1'b1; stall_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr",  rom_addr,      32'h14);
      check("stall_idpc",  id_pc,         32'h10);
      check("stall_inst",  id_inst,       rom_word(32'h10));
      check("stall_valid", 32'(id_valid), 32'h1);
    end
    stall_id = 1'b0;
    step();
    check("bub_valid", 32'(id_valid), 32'h0);
    check("bub_inst",  id_inst,       32'h0);
    check("bub_addr",  rom_addr,      32'h14);
    stall_if = 1'b0;
    step();
    check("resume_addr", rom_addr, 32'h18);
    check("resume_idpc", id_pc,    32'h14);

    // Flush beats stall and branch
    flush = 1'b1; new_pc = 32'h20; stall_if = 1'b1; branch_flag = 1'b1; branch_target = 32'h80;
    step();
    check("flp_addr",  rom_addr,      32'h20);
    check("flp_valid", 32'(id_valid), 32'h0);
    check("flp_inst",  id_inst,       32'h0);
    check("flp_idpc",  id_pc,         32'h0);
    flush = 1'b0; stall_if = 1'b0; branch_flag = 1'b0;
    step();
    check("flp_next", rom_addr, 32'h24);
    check("flp_id",   id_pc,    32'h20);

    // Wrap-around at the top of the address space
    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    check("wrap_top", rom_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr", rom_addr, 32'h0);
    check("wrap_idpc", id_pc,    32'hFFFF_FFFC);
    check("wrap_inst", id_inst,  rom_word(32'hFFFF_FFFC));

    // Misaligned flush target, then advance to 0x30
    flush = 1'b1; new_pc = 32'h2B;
    step();
    flush = 1'b0;
    check("fl_align", rom_addr, 32'h28);
    step();
    step();
    check("pre_rst_addr", rom_addr, 32'h30);

    // Async reset between edges
    rst = 1'b0;
    #1;
    check("arst_ce",    32'(rom_ce),   32'h0);
    check("arst_valid", 32'(id_valid), 32'h0);
    check("arst_inst",  id_inst,       32'h0);
    check("arst_addr",  rom_addr,      32'h0);
    #2 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rel_ce",    32'(rom_ce),   32'h1);
    check("rel_addr",  rom_addr,      32'h0);
    check("rel_valid", 32'(id_valid), 32'h0);
    step();
    check("rel_addr4", rom_addr,      32'h4);
    check("rel_inst0", id_inst,       rom_word(32'h0));
    check("rel_valid1", 32'(id_valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
